// File: rtl/bsg_arb_pkg.sv
// rtl/bsg_arb_pkg.sv - shared arbiter state enum and rotate-width helper
package bsg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // The rotate is done on a doubled copy of the request vector.
    function automatic int rot_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/bsg_encode_one_hot.sv
// rtl/bsg_encode_one_hot.sv - one-hot (or zero) to binary index encoder
module bsg_encode_one_hot #(
    parameter int width_p = 16,
    localparam int lg_width_lp = $clog2(width_p)
) (
    input  logic [width_p-1:0]     i,
    output logic [lg_width_lp-1:0] addr_o,
    output logic                   v_o
);

    // OR together the indices of set bits; exact for one-hot, 0 for all-zero.
    always_comb begin
        addr_o = '0;
        for (int k = 0; k < width_p; k++) begin
            if (i[k]) begin
                addr_o = addr_o | lg_width_lp'(k);
            end
        end
    end

    assign v_o = |i;

endmodule

// File: rtl/bsg_arb_rr_encoded.sv
// rtl/bsg_arb_rr_encoded.sv - registered round-robin arbiter with binary tag; optional lock via BSG_ARB_RR_ENCODED_LOCK_EN
module bsg_arb_rr_encoded
    import bsg_arb_pkg::*;
#(
    parameter int width_p = 16,
    localparam int lg_width_lp = $clog2(width_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_p-1:0]     reqs_i,
    input  logic                   last_i,
    input  logic                   yumi_i,
    output logic [width_p-1:0]     grants_o,
    output logic [lg_width_lp-1:0] tag_o,
    output logic                   v_o
);

    localparam int rot_width_lp = rot_width(width_p);

    arb_state_e               state_r;
    logic [width_p-1:0]       grant_r;
    logic [lg_width_lp-1:0]   ptr_r;
    logic [lg_width_lp-1:0]   ptr_next;
    logic [width_p-1:0]       idle_pick;
    logic [width_p-1:0]       rearb_pick;
    logic                     last_eff;

    // Rotate requests so ptr lands at bit 0, isolate the lowest set bit,
    // then rotate the one-hot result back to its original position.
    function automatic logic [width_p-1:0] rr_pick(
        input logic [width_p-1:0]     reqs,
        input logic [lg_width_lp-1:0] ptr
    );
        logic [width_p-1:0] rot;
        logic [width_p-1:0] first;
        logic [rot_width_lp-1:0] dbl;
        dbl   = {reqs, reqs} >> ptr;
        rot   = dbl[width_p-1:0];
        first = rot & (~rot + width_p'(1));
        dbl   = {first, first} >> (width_p - int'(ptr));
        return dbl[width_p-1:0];
    endfunction

`ifdef BSG_ARB_RR_ENCODED_LOCK_EN
    assign last_eff = last_i;
`else
    assign last_eff = 1'b1;
`endif

    // Power-of-two width: the pointer wraps to 0 naturally past width_p-1.
    assign ptr_next = tag_o + lg_width_lp'(1);

    // Candidate winners: fresh arbitration from IDLE, and the same-cycle
    // re-arbitration after a last accept with the current winner masked out.
    always_comb begin
        idle_pick  = rr_pick(reqs_i, ptr_r);
        rearb_pick = rr_pick(reqs_i & ~grant_r, ptr_next);
    end

    // Grant FSM: grant is held until the final accepted beat, then rotates.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            grant_r <= '0;
            ptr_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    grant_r <= idle_pick;
                    state_r <= (idle_pick != '0) ? GRANT : IDLE;
                end
                GRANT: begin
                    if (yumi_i && last_eff) begin
                        ptr_r   <= ptr_next;
                        grant_r <= rearb_pick;
                        state_r <= (rearb_pick != '0) ? GRANT : IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    bsg_encode_one_hot #(.width_p(width_p)) encode (
        .i      (grant_r),
        .addr_o (tag_o),
        .v_o    (v_o)
    );

    assign grants_o = grant_r;

    // The granted requester must keep requesting until its last accept.
    a_hold_req: assert property (@(posedge clk_i) disable iff (reset_i)
        (grant_r != '0) |-> ((grant_r & reqs_i) != '0));

    // The consumer may only accept a valid grant.
    a_yumi_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        yumi_i |-> v_o);

endmodule
